// File: rtl/gf180mcu_osu_sc_9t_oai31_bist.sv
// Self-test sequencer for the OAI31 cell: walks all 16 input vectors,
// samples Y after a settle window and records mismatches.
module gf180mcu_osu_sc_9t_oai31_bist #(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Y,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERRCNT,
  output logic       FAILVLD,
  output logic [3:0] FAILVEC
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     st, st_n;
  logic [3:0] v, v_n;
  logic [3:0] loop, loop_n;
  logic [3:0] wcnt, wcnt_n;
  logic [3:0] drv, drv_n;
  logic [3:0] fvec_n;
  logic [4:0] err_n;
  logic       busy_n, done_n, pass_n, fvld_n;
  logic       exp_y, miss;

  assign exp_y = ~((v[0] | v[1] | v[2]) & v[3]);
  assign miss  = (Y != exp_y);
  assign {B, A2, A1, A0} = drv;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st      <= S_IDLE;
      v       <= 4'd0;
      loop    <= 4'd0;
      wcnt    <= 4'd0;
      drv     <= 4'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      ERRCNT  <= 5'd0;
      FAILVLD <= 1'b0;
      FAILVEC <= 4'd0;
    end else begin
      st      <= st_n;
      v       <= v_n;
      loop    <= loop_n;
      wcnt    <= wcnt_n;
      drv     <= drv_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
      PASS    <= pass_n;
      ERRCNT  <= err_n;
      FAILVLD <= fvld_n;
      FAILVEC <= fvec_n;
    end
  end

  always_comb begin
    st_n   = st;
    v_n    = v;
    loop_n = loop;
    wcnt_n = wcnt;
    drv_n  = drv;
    busy_n = BUSY;
    done_n = DONE;
    pass_n = PASS;
    err_n  = ERRCNT;
    fvld_n = FAILVLD;
    fvec_n = FAILVEC;
    unique case (st)
      S_IDLE, S_DONE: begin
        if (START) begin
          st_n   = S_WAIT;
          v_n    = 4'd0;
          loop_n = 4'd0;
          wcnt_n = 4'd0;
          drv_n  = 4'd0;
          busy_n = 1'b1;
          done_n = 1'b0;
          pass_n = 1'b0;
          err_n  = 5'd0;
          fvld_n = 1'b0;
          fvec_n = 4'd0;
        end
      end
      S_WAIT: begin
        wcnt_n = wcnt + 4'd1;
        if (wcnt == 4'(SETTLE - 1))
          st_n = S_CHECK;
      end
      S_CHECK: begin
        if (miss) begin
          if (ERRCNT != 5'd31)
            err_n = ERRCNT + 5'd1;
          if (!FAILVLD) begin
            fvld_n = 1'b1;
            fvec_n = v;
          end
        end
        // pass decision must see this cycle's mismatch
        if (v == 4'd15 && loop == 4'(LOOPS - 1)) begin
          st_n   = S_DONE;
          done_n = 1'b1;
          busy_n = 1'b0;
          pass_n = (err_n == 5'd0);
          drv_n  = 4'd0;
        end else begin
          st_n   = S_WAIT;
          v_n    = v + 4'd1;
          drv_n  = v + 4'd1;
          wcnt_n = 4'd0;
          if (v == 4'd15)
            loop_n = loop + 4'd1;
        end
      end
      default: ;
    endcase
  end

endmodule
